lane_writeback_unit: RTL
========================

# lane_writeback_unit

Per-lane writeback stage that sits directly upstream of the lane register file and owns its single write port (REG_WRITE / rd / write_data). It merges ALU results for the current instruction with asynchronously returning memory load data. Load responses are buffered in a small FIFO, and the unit commits exactly one write per SIMD UPDATE state. It also keeps a per-register pending-load scoreboard, which the scheduler uses for RAW hazard stalls.

## Interface
- DATA_WIDTH, 64, register data width
- DATA_REG_ADDR_WIDTH, 7, destination register index width
- NUM_REGISTERS, 32, registers per lane
- MEM_FIFO_DEPTH, 4, load-response buffer entries (power of 2)
- PRE_UPDATE_STATE, 3'b101, SIMD state immediately preceding UPDATE
- UPDATE_STATE, 3'b110, SIMD state in which the register file samples its write port

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset: asynchronous, active-low
- enable  in  1  lane enable; gates selection and commit
- simd_state  in  3  current SIMD pipeline state
- alu_valid  in  1  ALU result for the current instruction present; held stable through UPDATE
- alu_rd  in  DATA_REG_ADDR_WIDTH  ALU destination
- alu_data  in  DATA_WIDTH  ALU result
- ld_issue_valid  in  1  load issued this cycle
- ld_issue_rd  in  DATA_REG_ADDR_WIDTH  load destination
- mem_valid  in  1  load response offered
- mem_ready  out  1  FIFO can accept; transfer when mem_valid && mem_ready
- mem_rd  in  DATA_REG_ADDR_WIDTH  response destination
- mem_data  in  DATA_WIDTH  response data
- REG_WRITE  out  1  write strobe to register file
- wb_rd  out  DATA_REG_ADDR_WIDTH  write address to register file rd
- write_data  out  DATA_WIDTH  write data to register file
- alu_stall  out  1  ALU result not committed this UPDATE; scheduler must replay
- pending_mask  out  NUM_REGISTERS  bit r set = load to r outstanding
- fifo_count  out  $clog2(MEM_FIFO_DEPTH)+1  buffered responses
- ro_violation  out  1  sticky: write to non-writable register dropped

## Operation
- Writable destinations are 4..27. Any rd in 0..3, 28..31 or ≥32 is non-writable.
- FIFO: push on mem_valid && mem_ready, regardless of enable. mem_ready = (fifo_count != MEM_FIFO_DEPTH), derived from the registered count only. A pop at the same edge does not make room for that edge's push.
- Selection happens at the rising edge where enable && simd_state == PRE_UPDATE_STATE. Priority:
  1. FIFO full: pop head into output regs. If alu_valid, set alu_stall.
  2. Else alu_valid: latch ALU rd/data.
  3. Else FIFO non-empty: pop head.
  4. Else REG_WRITE = 0.
- An entry pushed at the selection edge is not eligible until the next selection.
- Non-writable selection: the source is still consumed (popped / ALU counted as committed), REG_WRITE stays 0, and ro_violation is set until reset.
- Commit: REG_WRITE, wb_rd, write_data are held from the selection edge through the UPDATE cycle. At the rising edge where simd_state == UPDATE_STATE, REG_WRITE and alu_stall clear, and, if the committed write was a memory response, pending_mask[wb_rd] clears.
- Scoreboard: ld_issue_valid to a writable rd sets pending_mask[rd]; non-writable rd is ignored. If set and clear hit the same bit on the same edge, set wins. A second load to an already-pending rd leaves the bit set, and the bit clears at the first matching commit. The scheduler must not issue such loads.
- enable = 0: no selection, no pop, no commit-clear. FIFO push and scoreboard set continue.

## Timing
- Reset (rst = 0, asynchronous): REG_WRITE = 0, wb_rd = 0, write_data = 0, alu_stall = 0, pending_mask = 0, fifo_count = 0 (mem_ready = 1), ro_violation = 0.
- Release of rst is synchronous to clk. Reset mid-operation discards all FIFO entries and any uncommitted write.
- Latency:
  - ALU result to register file: selection edge plus one UPDATE cycle.
  - Memory response: at least 1 cycle in the FIFO before it can be selected.
- All outputs are registered except mem_ready, which is a registered-count compare.
- FIFO pointers wrap modulo MEM_FIFO_DEPTH. fifo_count never exceeds MEM_FIFO_DEPTH or underflows.

## Test plan
- Reset, then alu_valid, alu_rd = 5, alu_data = 0xDEAD through PRE_UPDATE → UPDATE -> REG_WRITE = 1, wb_rd = 5, write_data = 0xDEAD during UPDATE; REG_WRITE = 0 after it.
- ld_issue rd = 9; later mem response rd = 9, data = 0x1234, with no ALU -> pending_mask[9] = 1 until the UPDATE edge commits 0x1234, then pending_mask = 0.
- Push 4 responses (rd 10..13) -> mem_ready = 0, fifo_count = 4; next selection with alu_valid -> memory rd 10 committed, alu_stall = 1, fifo_count = 3, mem_ready = 1.
- ALU write to rd = 2 and a memory response to rd = 30 -> no REG_WRITE, ro_violation = 1, FIFO drained.
- Same-edge ld_issue rd = 7 and commit of a memory response rd = 7 -> pending_mask[7] stays 1.
- Assert rst low asynchronously mid-UPDATE with 3 FIFO entries -> all outputs go to their reset values immediately, fifo_count = 0.

Source files
------------

// File: rtl/lane_writeback_unit.sv
// lane_writeback_unit
// Owns the lane register-file write port. Each SIMD UPDATE commits at most one
// write, chosen at the preceding PRE_UPDATE edge from either the ALU result of
// the current instruction or a buffered memory load response. A per-register
// scoreboard tracks loads whose data has not yet been written back.
module lane_writeback_unit #(
  parameter int           DATA_WIDTH          = 64,
  parameter int           DATA_REG_ADDR_WIDTH = 7,
  parameter int           NUM_REGISTERS       = 32,
  parameter int           MEM_FIFO_DEPTH      = 4,
  parameter logic [2:0]   PRE_UPDATE_STATE    = 3'b101,
  parameter logic [2:0]   UPDATE_STATE        = 3'b110
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enable,
  input  logic [2:0]                            simd_state,
  input  logic                                  alu_valid,
  input  logic [DATA_REG_ADDR_WIDTH-1:0]        alu_rd,
  input  logic [DATA_WIDTH-1:0]                 alu_data,
  input  logic                                  ld_issue_valid,
  input  logic [DATA_REG_ADDR_WIDTH-1:0]        ld_issue_rd,
  input  logic                                  mem_valid,
  output logic                                  mem_ready,
  input  logic [DATA_REG_ADDR_WIDTH-1:0]        mem_rd,
  input  logic [DATA_WIDTH-1:0]                 mem_data,
  output logic                                  REG_WRITE,
  output logic [DATA_REG_ADDR_WIDTH-1:0]        wb_rd,
  output logic [DATA_WIDTH-1:0]                 write_data,
  output logic                                  alu_stall,
  output logic [NUM_REGISTERS-1:0]              pending_mask,
  output logic [$clog2(MEM_FIFO_DEPTH):0]       fifo_count,
  output logic                                  ro_violation
);

  localparam int PTR_W = $clog2(MEM_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RW    = DATA_REG_ADDR_WIDTH;

  // Registers 0..3 are hardwired/special and 28..31 are reserved; only the
  // middle band may be written back.
  function automatic logic is_writable(input logic [RW-1:0] rd);
    return (rd >= RW'(4)) && (rd <= RW'(27));
  endfunction

  // One-hot scoreboard bit for a register index; out-of-range indexes map to 0.
  function automatic logic [NUM_REGISTERS-1:0] reg_onehot(input logic [RW-1:0] rd);
    logic [NUM_REGISTERS-1:0] v;
    v = '0;
    for (int r = 0; r < NUM_REGISTERS; r++) begin
      v[r] = (rd == RW'(r));
    end
    return v;
  endfunction

  // Load-response FIFO storage and bookkeeping
  logic [RW-1:0]          fifo_rd_r   [MEM_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  fifo_data_r [MEM_FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       count_r;
  logic [CNT_W-1:0]       count_nxt_s;

  // Write-port and status registers
  logic                      reg_write_r;
  logic [RW-1:0]             wb_rd_r;
  logic [DATA_WIDTH-1:0]     write_data_r;
  logic                      src_mem_r;
  logic                      alu_stall_r;
  logic                      ro_violation_r;
  logic [NUM_REGISTERS-1:0]  pending_r;

  logic                      reg_write_nxt_s;
  logic [RW-1:0]             wb_rd_nxt_s;
  logic [DATA_WIDTH-1:0]     write_data_nxt_s;
  logic                      src_mem_nxt_s;
  logic                      alu_stall_nxt_s;
  logic                      ro_violation_nxt_s;
  logic [NUM_REGISTERS-1:0]  pending_nxt_s;

  logic                      push_s;
  logic                      pop_s;
  logic                      full_s;
  logic                      empty_s;
  logic                      sel_s;
  logic                      commit_s;
  logic                      cand_take_s;
  logic [RW-1:0]             cand_rd_s;
  logic [DATA_WIDTH-1:0]     cand_data_s;
  logic                      cand_mem_s;
  logic [NUM_REGISTERS-1:0]  set_mask_s;
  logic [NUM_REGISTERS-1:0]  clr_mask_s;

  // Readiness comes purely from the registered count, so a same-edge pop
  // never frees room for a same-edge push.
  assign full_s    = (count_r == CNT_W'(MEM_FIFO_DEPTH));
  assign empty_s   = (count_r == CNT_W'(0));
  assign mem_ready = !full_s;
  assign push_s    = mem_valid && !full_s;
  assign sel_s     = enable && (simd_state == PRE_UPDATE_STATE);
  assign commit_s  = enable && (simd_state == UPDATE_STATE);

  // Pick the write source for the coming UPDATE; a full FIFO outranks the ALU
  // so responses can never back up indefinitely.
  always_comb begin
    pop_s       = 1'b0;
    cand_take_s = 1'b0;
    cand_rd_s   = fifo_rd_r[rd_ptr_r];
    cand_data_s = fifo_data_r[rd_ptr_r];
    cand_mem_s  = 1'b1;
    if (sel_s) begin
      if (full_s) begin
        pop_s       = 1'b1;
        cand_take_s = 1'b1;
      end else if (alu_valid) begin
        cand_take_s = 1'b1;
        cand_rd_s   = alu_rd;
        cand_data_s = alu_data;
        cand_mem_s  = 1'b0;
      end else if (!empty_s) begin
        pop_s       = 1'b1;
        cand_take_s = 1'b1;
      end else begin
        cand_take_s = 1'b0;
      end
    end else begin
      cand_take_s = 1'b0;
    end
  end

  // Next state of the write port, stall flag and violation flag
  always_comb begin
    reg_write_nxt_s    = reg_write_r;
    wb_rd_nxt_s        = wb_rd_r;
    write_data_nxt_s   = write_data_r;
    src_mem_nxt_s      = src_mem_r;
    alu_stall_nxt_s    = alu_stall_r;
    ro_violation_nxt_s = ro_violation_r;
    if (sel_s) begin
      alu_stall_nxt_s = full_s && alu_valid;
      if (cand_take_s) begin
        if (is_writable(cand_rd_s)) begin
          reg_write_nxt_s  = 1'b1;
          wb_rd_nxt_s      = cand_rd_s;
          write_data_nxt_s = cand_data_s;
          src_mem_nxt_s    = cand_mem_s;
        end else begin
          // Source is consumed but the write is dropped.
          reg_write_nxt_s    = 1'b0;
          src_mem_nxt_s      = 1'b0;
          ro_violation_nxt_s = 1'b1;
        end
      end else begin
        reg_write_nxt_s = 1'b0;
        src_mem_nxt_s   = 1'b0;
      end
    end else if (commit_s) begin
      reg_write_nxt_s = 1'b0;
      alu_stall_nxt_s = 1'b0;
    end else begin
      reg_write_nxt_s = reg_write_r;
    end
  end

  // Scoreboard update; a same-edge set of a bit overrides its clear.
  always_comb begin
    if (ld_issue_valid && is_writable(ld_issue_rd)) begin
      set_mask_s = reg_onehot(ld_issue_rd);
    end else begin
      set_mask_s = '0;
    end
    if (commit_s && reg_write_r && src_mem_r) begin
      clr_mask_s = reg_onehot(wb_rd_r);
    end else begin
      clr_mask_s = '0;
    end
    pending_nxt_s = (pending_r & ~clr_mask_s) | set_mask_s;
  end

  // FIFO occupancy next value
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO payload storage; contents are don't-care until counted valid
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_rd_r[wr_ptr_r]   <= mem_rd;
      fifo_data_r[wr_ptr_r] <= mem_data;
    end
  end

  // FIFO pointers and count; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  // Write-port, stall, violation and scoreboard registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_r    <= 1'b0;
      wb_rd_r        <= '0;
      write_data_r   <= '0;
      src_mem_r      <= 1'b0;
      alu_stall_r    <= 1'b0;
      ro_violation_r <= 1'b0;
      pending_r      <= '0;
    end else begin
      reg_write_r    <= reg_write_nxt_s;
      wb_rd_r        <= wb_rd_nxt_s;
      write_data_r   <= write_data_nxt_s;
      src_mem_r      <= src_mem_nxt_s;
      alu_stall_r    <= alu_stall_nxt_s;
      ro_violation_r <= ro_violation_nxt_s;
      pending_r      <= pending_nxt_s;
    end
  end

  assign REG_WRITE    = reg_write_r;
  assign wb_rd        = wb_rd_r;
  assign write_data   = write_data_r;
  assign alu_stall    = alu_stall_r;
  assign pending_mask = pending_r;
  assign fifo_count   = count_r;
  assign ro_violation = ro_violation_r;

endmodule
